// File: rtl/toy_bus_mem_arb_if.sv
// Requester-side bus bundle for toy_bus_mem_arb: one request channel
// (vld/rdy plus payload) and one read-ack channel (vld/rdy plus payload).
// master : the requester (drives the request and ack_rdy)
// slave  : the arbiter  (drives req_rdy and the ack channel)
interface toy_bus_mem_arb_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 256;
  localparam int unsigned STRB_W = 32;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned SB_W   = 10;

  logic              req_vld;
  logic              req_rdy;
  logic [ADDR_W-1:0] req_addr;
  logic [STRB_W-1:0] req_strb;
  logic [DATA_W-1:0] req_data;
  logic              req_opcode;
  logic [ID_W-1:0]   req_src_id;
  logic [SB_W-1:0]   req_sideband;
  logic              ack_vld;
  logic              ack_rdy;
  logic [DATA_W-1:0] ack_data;
  logic [SB_W-1:0]   ack_sideband;
  logic [ID_W-1:0]   ack_tgt_id;

  modport master (
    output req_vld, req_addr, req_strb, req_data, req_opcode, req_src_id,
           req_sideband, ack_rdy,
    input  req_rdy, ack_vld, ack_data, ack_sideband, ack_tgt_id
  );

  modport slave (
    input  req_vld, req_addr, req_strb, req_data, req_opcode, req_src_id,
           req_sideband, ack_rdy,
    output req_rdy, ack_vld, ack_data, ack_sideband, ack_tgt_id
  );
endinterface

// File: rtl/toy_bus_mem_arb.sv
// Two-port arbiter in front of a single-ported memory with one-cycle read
// latency. Writes are fire-and-forget; each read returns one ack on the
// port that issued it, and a port holds at most one read in flight.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   in0, in1           : requester buses (toy_bus_mem_arb_if.slave)
//   mem_en ... mem_req_sideband : memory request (combinational from grant)
//   mem_rd_data, mem_ack_sideband : memory read return, one cycle after mem_en
// Build option: TOY_BUS_MEM_ARB_FIXED_PRIO_EN makes in0 win every tie
// instead of round-robin.
module toy_bus_mem_arb #(
  parameter int unsigned ADDR_LSB = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  toy_bus_mem_arb_if.slave     in0,
  toy_bus_mem_arb_if.slave     in1,
  output logic                 mem_en,
  output logic [31:0]          mem_addr,
  output logic                 mem_wr_en,
  output logic [255:0]         mem_wr_data,
  output logic [31:0]          mem_wr_byte_en,
  input  logic [255:0]         mem_rd_data,
  input  logic [9:0]           mem_ack_sideband,
  output logic [9:0]           mem_req_sideband
);
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned WADDR_W = 24;
  localparam int unsigned DATA_W  = 256;
  localparam int unsigned ID_W    = 4;
  localparam int unsigned SB_W    = 10;

  logic [1:0]        pend_q;
  logic [1:0]        ack_vld_q;
  logic              last_grant_q;
  logic [DATA_W-1:0] ack_data_q [2];
  logic [SB_W-1:0]   ack_sb_q   [2];
  logic [ID_W-1:0]   ack_tgt_q  [2];

  logic [1:0]        elig;
  logic [1:0]        grant;
  logic [1:0]        rd_grant;
  logic [1:0]        ack_rdy;
  logic [ID_W-1:0]   src_id [2];

  // Address bits outside the forwarded word-address window are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{in0.req_addr, in1.req_addr};

  // A read is blocked while its port still has a read pending or an ack
  // waiting to drain; writes never produce an ack and are always eligible.
  assign elig[0] = in0.req_vld & (in0.req_opcode | ~(pend_q[0] | ack_vld_q[0]));
  assign elig[1] = in1.req_vld & (in1.req_opcode | ~(pend_q[1] | ack_vld_q[1]));

  // Single grant per cycle; ties go to the port not granted last time.
  always_comb begin
    grant = 2'b00;
    if (!rst) begin
      if (elig == 2'b11) begin
`ifdef TOY_BUS_MEM_ARB_FIXED_PRIO_EN
        grant = 2'b01;
`else
        grant = last_grant_q ? 2'b01 : 2'b10;
`endif
      end else begin
        grant = elig;
      end
    end
  end

  assign rd_grant  = grant & ~{in1.req_opcode, in0.req_opcode};
  assign ack_rdy   = {in1.ack_rdy, in0.ack_rdy};
  assign src_id[0] = in0.req_src_id;
  assign src_id[1] = in1.req_src_id;

  assign in0.req_rdy = grant[0];
  assign in1.req_rdy = grant[1];

  // Memory request mux; all-zero when nothing is granted.
  always_comb begin
    mem_en           = 1'b0;
    mem_addr         = '0;
    mem_wr_en        = 1'b0;
    mem_wr_data      = '0;
    mem_wr_byte_en   = '0;
    mem_req_sideband = '0;
    if (grant[0]) begin
      mem_en           = 1'b1;
      mem_addr         = ADDR_W'(in0.req_addr[ADDR_LSB +: WADDR_W]);
      mem_wr_en        = in0.req_opcode;
      mem_wr_data      = in0.req_data;
      mem_wr_byte_en   = in0.req_strb;
      mem_req_sideband = in0.req_sideband;
    end else if (grant[1]) begin
      mem_en           = 1'b1;
      mem_addr         = ADDR_W'(in1.req_addr[ADDR_LSB +: WADDR_W]);
      mem_wr_en        = in1.req_opcode;
      mem_wr_data      = in1.req_data;
      mem_wr_byte_en   = in1.req_strb;
      mem_req_sideband = in1.req_sideband;
    end
  end

  // Read tracking and ack registers. Reset drops any read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q       <= 2'b00;
      ack_vld_q    <= 2'b00;
      last_grant_q <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        ack_data_q[i] <= '0;
        ack_sb_q[i]   <= '0;
        ack_tgt_q[i]  <= '0;
      end
    end else begin
      if (|grant) last_grant_q <= grant[1];
      pend_q <= rd_grant;
      for (int i = 0; i < 2; i++) begin
        if (rd_grant[i]) ack_tgt_q[i] <= src_id[i];
        if (pend_q[i]) begin
          ack_vld_q[i]  <= 1'b1;
          ack_data_q[i] <= mem_rd_data;
          ack_sb_q[i]   <= mem_ack_sideband;
        end else if (ack_vld_q[i] && ack_rdy[i]) begin
          ack_vld_q[i]  <= 1'b0;
        end
      end
    end
  end

  assign in0.ack_vld      = ack_vld_q[0];
  assign in0.ack_data     = ack_data_q[0];
  assign in0.ack_sideband = ack_sb_q[0];
  assign in0.ack_tgt_id   = ack_tgt_q[0];
  assign in1.ack_vld      = ack_vld_q[1];
  assign in1.ack_data     = ack_data_q[1];
  assign in1.ack_sideband = ack_sb_q[1];
  assign in1.ack_tgt_id   = ack_tgt_q[1];
endmodule

// File: tb/tb_toy_bus_mem_arb.sv
// Directed self-checking bench for toy_bus_mem_arb. Inputs change on the
// falling edge; outputs are sampled 1 ns later, away from the rising edge.
module tb_toy_bus_mem_arb;
  logic         clk = 1'b0;
  logic         rst;
  logic         mem_en;
  logic [31:0]  mem_addr;
  logic         mem_wr_en;
  logic [255:0] mem_wr_data;
  logic [31:0]  mem_wr_byte_en;
  logic [255:0] mem_rd_data;
  logic [9:0]   mem_ack_sideband;
  logic [9:0]   mem_req_sideband;

  int pass_cnt = 0;
  int total    = 0;

  toy_bus_mem_arb_if in0_if ();
  toy_bus_mem_arb_if in1_if ();

  toy_bus_mem_arb #(.ADDR_LSB(5)) dut (
    .clk              (clk),
    .rst              (rst),
    .in0              (in0_if),
    .in1              (in1_if),
    .mem_en           (mem_en),
    .mem_addr         (mem_addr),
    .mem_wr_en        (mem_wr_en),
    .mem_wr_data      (mem_wr_data),
    .mem_wr_byte_en   (mem_wr_byte_en),
    .mem_rd_data      (mem_rd_data),
    .mem_ack_sideband (mem_ack_sideband),
    .mem_req_sideband (mem_req_sideband)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_all();
    in0_if.req_vld = 1'b0; in0_if.req_opcode = 1'b0; in0_if.ack_rdy = 1'b1;
    in0_if.req_addr = '0; in0_if.req_strb = '0; in0_if.req_data = '0;
    in0_if.req_src_id = '0; in0_if.req_sideband = '0;
    in1_if.req_vld = 1'b0; in1_if.req_opcode = 1'b0; in1_if.ack_rdy = 1'b1;
    in1_if.req_addr = '0; in1_if.req_strb = '0; in1_if.req_data = '0;
    in1_if.req_src_id = '0; in1_if.req_sideband = '0;
    mem_rd_data = '0; mem_ack_sideband = '0;
  endtask

  task automatic do_reset();
    step(); idle_all(); rst = 1'b1;
    step(); step(); rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1'b1;
    in0_if.req_vld = 1'b1; in0_if.req_opcode = 1'b1;
    in1_if.req_vld = 1'b1; in1_if.req_opcode = 1'b0;
    step(); step(); #1;
    total++; if (in0_if.req_rdy !== 1'b0) $display("FAIL reset_in0_rdy got=%b exp=0", in0_if.req_rdy); else pass_cnt++;
    total++; if (in1_if.req_rdy !== 1'b0) $display("FAIL reset_in1_rdy got=%b exp=0", in1_if.req_rdy); else pass_cnt++;
    total++; if (mem_en !== 1'b0) $display("FAIL reset_mem_en got=%b exp=0", mem_en); else pass_cnt++;
    total++; if (mem_wr_data !== 256'd0) $display("FAIL reset_mem_wr_data got=%h exp=0", mem_wr_data); else pass_cnt++;
    total++; if (in0_if.ack_vld !== 1'b0 || in1_if.ack_vld !== 1'b0)
      $display("FAIL reset_ack_vld got=%b%b exp=00", in1_if.ack_vld, in0_if.ack_vld); else pass_cnt++;
    step(); idle_all(); rst = 1'b0;
  endtask

  task automatic test_read();
    logic [255:0] exp_d;
    exp_d = {32{8'hA5}};
    step();
    in0_if.req_vld = 1'b1; in0_if.req_opcode = 1'b0; in0_if.req_addr = 32'h40;
    in0_if.req_src_id = 4'h3; in0_if.req_sideband = 10'h155; in0_if.ack_rdy = 1'b1;
    mem_rd_data = exp_d; mem_ack_sideband = 10'h2AA;
    #1;
    total++; if (in0_if.req_rdy !== 1'b1) $display("FAIL rd_grant got=%b exp=1", in0_if.req_rdy); else pass_cnt++;
    total++; if (mem_en !== 1'b1 || mem_wr_en !== 1'b0) $display("FAIL rd_mem_en got=%b/%b exp=1/0", mem_en, mem_wr_en); else pass_cnt++;
    total++; if (mem_addr !== 32'h2) $display("FAIL rd_mem_addr got=%h exp=00000002", mem_addr); else pass_cnt++;
    total++; if (mem_req_sideband !== 10'h155) $display("FAIL rd_req_sb got=%h exp=155", mem_req_sideband); else pass_cnt++;
    step(); in0_if.req_vld = 1'b0; #1;
    total++; if (in0_if.ack_vld !== 1'b0) $display("FAIL rd_ack_early got=%b exp=0", in0_if.ack_vld); else pass_cnt++;
    total++; if (mem_en !== 1'b0) $display("FAIL rd_idle_mem_en got=%b exp=0", mem_en); else pass_cnt++;
    step(); mem_rd_data = '0; mem_ack_sideband = '0; #1;
    total++; if (in0_if.ack_vld !== 1'b1) $display("FAIL rd_ack_vld got=%b exp=1", in0_if.ack_vld); else pass_cnt++;
    total++; if (in0_if.ack_data !== exp_d) $display("FAIL rd_ack_data got=%h exp=%h", in0_if.ack_data, exp_d); else pass_cnt++;
    total++; if (in0_if.ack_tgt_id !== 4'h3) $display("FAIL rd_ack_tgt got=%h exp=3", in0_if.ack_tgt_id); else pass_cnt++;
    total++; if (in0_if.ack_sideband !== 10'h2AA) $display("FAIL rd_ack_sb got=%h exp=2aa", in0_if.ack_sideband); else pass_cnt++;
    total++; if (in1_if.ack_vld !== 1'b0) $display("FAIL rd_ack_wrong_port got=%b exp=0", in1_if.ack_vld); else pass_cnt++;
    step(); #1;
    total++; if (in0_if.ack_vld !== 1'b0) $display("FAIL rd_ack_drained got=%b exp=0", in0_if.ack_vld); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic exp0;
    do_reset();
    in0_if.req_vld = 1'b1; in0_if.req_opcode = 1'b1; in0_if.req_data = {32{8'h11}};
    in1_if.req_vld = 1'b1; in1_if.req_opcode = 1'b1; in1_if.req_data = {32{8'h22}};
    for (int k = 0; k < 6; k++) begin
      #1;
`ifdef TOY_BUS_MEM_ARB_FIXED_PRIO_EN
      exp0 = 1'b1;
`else
      exp0 = (k % 2 == 0);
`endif
      total++; if (in0_if.req_rdy !== exp0 || in1_if.req_rdy !== ~exp0)
        $display("FAIL b2b_grant[%0d] got=%b%b exp=%b%b", k, in1_if.req_rdy, in0_if.req_rdy, ~exp0, exp0); else pass_cnt++;
      total++; if (mem_wr_data !== (exp0 ? {32{8'h11}} : {32{8'h22}}))
        $display("FAIL b2b_wr_data[%0d] got=%h", k, mem_wr_data); else pass_cnt++;
      step();
    end
    idle_all();
  endtask

  task automatic test_ack_backpressure();
    logic [255:0] exp_d;
    exp_d = {32{8'h5A}};
    do_reset();
    in1_if.req_vld = 1'b1; in1_if.req_opcode = 1'b0; in1_if.req_addr = 32'h80;
    in1_if.req_src_id = 4'h9; in1_if.req_sideband = 10'h0F0;
    mem_rd_data = exp_d; mem_ack_sideband = 10'h033;
    #1;
    total++; if (in1_if.req_rdy !== 1'b1 || mem_addr !== 32'h4)
      $display("FAIL bp_grant got=%b addr=%h exp=1 addr=4", in1_if.req_rdy, mem_addr); else pass_cnt++;
    step(); in1_if.req_vld = 1'b0; in1_if.ack_rdy = 1'b0;
    step();
    mem_rd_data = '0; mem_ack_sideband = '0;
    in1_if.req_vld = 1'b1; in1_if.req_addr = 32'hA0;
    in0_if.req_vld = 1'b1; in0_if.req_opcode = 1'b1; in0_if.req_data = {32{8'h77}};
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (in1_if.ack_vld !== 1'b1) $display("FAIL bp_ack_vld[%0d] got=%b exp=1", k, in1_if.ack_vld); else pass_cnt++;
      total++; if (in1_if.ack_data !== exp_d || in1_if.ack_sideband !== 10'h033 || in1_if.ack_tgt_id !== 4'h9)
        $display("FAIL bp_ack_hold[%0d] got=%h sb=%h tgt=%h", k, in1_if.ack_data, in1_if.ack_sideband, in1_if.ack_tgt_id); else pass_cnt++;
      total++; if (in1_if.req_rdy !== 1'b0) $display("FAIL bp_in1_blocked[%0d] got=%b exp=0", k, in1_if.req_rdy); else pass_cnt++;
      total++; if (in0_if.req_rdy !== 1'b1) $display("FAIL bp_in0_write[%0d] got=%b exp=1", k, in0_if.req_rdy); else pass_cnt++;
      step();
    end
    in0_if.req_vld = 1'b0; in1_if.ack_rdy = 1'b1; #1;
    total++; if (in1_if.ack_vld !== 1'b1 || in1_if.req_rdy !== 1'b0)
      $display("FAIL bp_drain_cycle got vld=%b rdy=%b exp vld=1 rdy=0", in1_if.ack_vld, in1_if.req_rdy); else pass_cnt++;
    step(); #1;
    total++; if (in1_if.ack_vld !== 1'b0 || in1_if.req_rdy !== 1'b1)
      $display("FAIL bp_after_drain got vld=%b rdy=%b exp vld=0 rdy=1", in1_if.ack_vld, in1_if.req_rdy); else pass_cnt++;
    step(); idle_all();
    step(); step(); step();
  endtask

  task automatic test_reset_inflight();
    do_reset();
    in0_if.req_vld = 1'b1; in0_if.req_opcode = 1'b0; in0_if.req_addr = 32'h40;
    mem_rd_data = {32{8'hC3}};
    #1;
    total++; if (in0_if.req_rdy !== 1'b1) $display("FAIL rst_rd_grant got=%b exp=1", in0_if.req_rdy); else pass_cnt++;
    step(); in0_if.req_vld = 1'b0; rst = 1'b1;
    in1_if.req_vld = 1'b1; in1_if.req_opcode = 1'b1; #1;
    total++; if (mem_en !== 1'b0 || in1_if.req_rdy !== 1'b0)
      $display("FAIL rst_outputs got mem_en=%b rdy=%b exp 0/0", mem_en, in1_if.req_rdy); else pass_cnt++;
    step(); rst = 1'b0; in1_if.req_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (in0_if.ack_vld !== 1'b0) $display("FAIL rst_no_ack[%0d] got=%b exp=0", k, in0_if.ack_vld); else pass_cnt++;
      step();
    end
    in0_if.req_vld = 1'b1; in0_if.req_opcode = 1'b1;
    in1_if.req_vld = 1'b1; in1_if.req_opcode = 1'b1; #1;
    total++; if (in0_if.req_rdy !== 1'b1 || in1_if.req_rdy !== 1'b0)
      $display("FAIL rst_first_tie got=%b%b exp=01", in1_if.req_rdy, in0_if.req_rdy); else pass_cnt++;
    step(); idle_all();
  endtask

  task automatic test_write_strb();
    step();
    in0_if.req_vld = 1'b1; in0_if.req_opcode = 1'b1; in0_if.req_addr = 32'h1000;
    in0_if.req_strb = 32'h0000000F; in0_if.req_data = {32{8'h3C}};
    #1;
    total++; if (mem_wr_en !== 1'b1 || mem_en !== 1'b1) $display("FAIL wr_en got=%b/%b exp=1/1", mem_en, mem_wr_en); else pass_cnt++;
    total++; if (mem_wr_byte_en !== 32'h0000000F) $display("FAIL wr_strb got=%h exp=0000000f", mem_wr_byte_en); else pass_cnt++;
    total++; if (mem_addr !== 32'h80) $display("FAIL wr_addr got=%h exp=00000080", mem_addr); else pass_cnt++;
    total++; if (mem_wr_data !== {32{8'h3C}}) $display("FAIL wr_data got=%h", mem_wr_data); else pass_cnt++;
    step(); idle_all();
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (in0_if.ack_vld !== 1'b0) $display("FAIL wr_no_ack[%0d] got=%b exp=0", k, in0_if.ack_vld); else pass_cnt++;
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    test_reset();
    test_read();
    test_back_to_back();
    test_ack_backpressure();
    test_reset_inflight();
    test_write_strb();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
